coax_transaction_ctrl: RTL and testbench

Sequences one 3270 coax transaction: forwards host command words to `coax_tx`, waits a bounded time for the response frame, then drains the response words from `coax_rx` to the host. It sits between the host/register interface and the `coax_tx`/`coax_rx` pair, owning their `load` and `data_read` strobes so no other logic drives them.

---
 rtl/coax_transaction_ctrl_if.sv | 45 ++++
 rtl/coax_transaction_ctrl.sv | 169 ++++++++++++++++
 tb/tb_coax_transaction_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/coax_transaction_ctrl_if.sv
// Bundle of every signal between the transaction controller and its
// surroundings: host command/response streams, the coax_tx/coax_rx pair
// and the status/result outputs.  The controller uses the slave view; the
// host, the coax blocks and the bench use the master view.
interface coax_transaction_ctrl_if;
    logic       start;
    logic [9:0] host_tx_data;
    logic       host_tx_valid;
    logic       host_tx_last;
    logic       host_tx_ready;
    logic [9:0] host_rx_data;
    logic       host_rx_valid;
    logic       host_rx_ready;
    logic       tx_load;
    logic [9:0] tx_data;
    logic       tx_ready;
    logic       tx_active;
    logic [9:0] rx_data;
    logic       rx_data_available;
    logic       rx_active;
    logic       rx_error;
    logic       rx_data_read;
    logic       busy;
    logic       done;
    logic       status_timeout;
    logic       status_error;
    logic       status_underrun;
    logic [7:0] rx_count;

    modport master (
        output start, host_tx_data, host_tx_valid, host_tx_last, host_rx_ready,
               tx_ready, tx_active, rx_data, rx_data_available, rx_active, rx_error,
        input  host_tx_ready, host_rx_data, host_rx_valid, tx_load, tx_data,
               rx_data_read, busy, done, status_timeout, status_error,
               status_underrun, rx_count
    );

    modport slave (
        input  start, host_tx_data, host_tx_valid, host_tx_last, host_rx_ready,
               tx_ready, tx_active, rx_data, rx_data_available, rx_active, rx_error,
        output host_tx_ready, host_rx_data, host_rx_valid, tx_load, tx_data,
               rx_data_read, busy, done, status_timeout, status_error,
               status_underrun, rx_count
    );
endinterface

// File: rtl/coax_transaction_ctrl.sv
// Sequences one 3270 coax transaction: streams host command words into
// coax_tx, waits a bounded time for the response frame, then hands each
// response word from coax_rx to the host.  This block is the only driver of
// the coax_tx load strobe and the coax_rx read strobe.
module coax_transaction_ctrl #(
    parameter int RESPONSE_TIMEOUT = 1000
) (
    input  logic                   clk,
    input  logic                   reset,
    coax_transaction_ctrl_if.slave bus
);

    localparam int CNT_W = $clog2(RESPONSE_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        TX,
        TX_DRAIN,
        RX_WAIT,
        RX_COLLECT,
        DONE
    } state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] timer_reg;
    logic [CNT_W-1:0] timer_next;
    logic             loaded_reg;
    logic             tx_load_reg;
    logic [9:0]       tx_data_reg;
    logic [9:0]       host_rx_data_reg;
    logic             host_rx_valid_reg;
    logic             rx_data_read_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             status_timeout_reg;
    logic             status_error_reg;
    logic             status_underrun_reg;
    logic [7:0]       rx_count_reg;

    logic tx_xfer;
    logic rx_capture;
    logic rx_accept;

    // Host word moves into tx_data; blocked while a load strobe is still
    // in flight so coax_tx sees one word per strobe.
    assign tx_xfer = (state_reg == TX) & bus.tx_ready & bus.host_tx_valid & ~tx_load_reg;

    // New response word is taken only when the holding register is free and
    // the previous read strobe has had a cycle to clear rx_data_available.
    assign rx_capture = (state_reg == RX_COLLECT) & ~bus.rx_error & bus.rx_data_available
                      & ~host_rx_valid_reg & ~rx_data_read_reg;

    assign rx_accept  = host_rx_valid_reg & bus.host_rx_ready;
    assign timer_next = timer_reg + CNT_W'(1);

    // Transaction FSM with all outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg           <= IDLE;
            timer_reg           <= '0;
            loaded_reg          <= 1'b0;
            tx_load_reg         <= 1'b0;
            tx_data_reg         <= '0;
            host_rx_data_reg    <= '0;
            host_rx_valid_reg   <= 1'b0;
            rx_data_read_reg    <= 1'b0;
            busy_reg            <= 1'b0;
            done_reg            <= 1'b0;
            status_timeout_reg  <= 1'b0;
            status_error_reg    <= 1'b0;
            status_underrun_reg <= 1'b0;
            rx_count_reg        <= '0;
        end else begin
            tx_load_reg      <= 1'b0;
            rx_data_read_reg <= 1'b0;
            done_reg         <= 1'b0;
            // A delivered word may still be waiting after the transaction
            // has finished, so acceptance is honoured in every state.
            if (rx_accept) begin
                host_rx_valid_reg <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        state_reg           <= TX;
                        busy_reg            <= 1'b1;
                        loaded_reg          <= 1'b0;
                        status_timeout_reg  <= 1'b0;
                        status_error_reg    <= 1'b0;
                        status_underrun_reg <= 1'b0;
                        rx_count_reg        <= '0;
                    end
                end
                TX: begin
                    if (tx_xfer) begin
                        tx_data_reg <= bus.host_tx_data;
                        tx_load_reg <= 1'b1;
                        loaded_reg  <= 1'b1;
                        if (bus.host_tx_last) begin
                            state_reg <= TX_DRAIN;
                        end
                    end else if (loaded_reg && !bus.tx_active && !tx_load_reg) begin
                        // Frame ended before the host supplied the last word.
                        status_underrun_reg <= 1'b1;
                        state_reg           <= DONE;
                    end
                end
                TX_DRAIN: begin
                    // Wait for the final strobe to be consumed and the frame to end.
                    if (!bus.tx_active && !tx_load_reg) begin
                        timer_reg <= '0;
                        state_reg <= RX_WAIT;
                    end
                end
                RX_WAIT: begin
                    timer_reg <= timer_next;
                    if (bus.rx_error) begin
                        status_error_reg <= 1'b1;
                        state_reg        <= DONE;
                    end else if (bus.rx_active || bus.rx_data_available) begin
                        state_reg <= RX_COLLECT;
                    end else if (timer_next == CNT_W'(RESPONSE_TIMEOUT)) begin
                        status_timeout_reg <= 1'b1;
                        state_reg          <= DONE;
                    end
                end
                RX_COLLECT: begin
                    if (bus.rx_error) begin
                        status_error_reg <= 1'b1;
                        state_reg        <= DONE;
                    end else if (rx_capture) begin
                        host_rx_data_reg  <= bus.rx_data;
                        host_rx_valid_reg <= 1'b1;
                        rx_data_read_reg  <= 1'b1;
                        if (rx_count_reg != 8'hFF) begin
                            rx_count_reg <= rx_count_reg + 8'd1;
                        end
                    end else if (!bus.rx_active && !bus.rx_data_available
                                 && !host_rx_valid_reg && !rx_data_read_reg) begin
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    done_reg  <= 1'b1;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.host_tx_ready   = tx_xfer;
    assign bus.tx_load         = tx_load_reg;
    assign bus.tx_data         = tx_data_reg;
    assign bus.host_rx_data    = host_rx_data_reg;
    assign bus.host_rx_valid   = host_rx_valid_reg;
    assign bus.rx_data_read    = rx_data_read_reg;
    assign bus.busy            = busy_reg;
    assign bus.done            = done_reg;
    assign bus.status_timeout  = status_timeout_reg;
    assign bus.status_error    = status_error_reg;
    assign bus.status_underrun = status_underrun_reg;
    assign bus.rx_count        = rx_count_reg;

endmodule

// File: tb/tb_coax_transaction_ctrl.sv
// Bench for coax_transaction_ctrl: behavioural coax_tx/coax_rx models plus a
// host model, stepped once per clock from a single thread.  Transaction
// vectors come from a table; reset and timing corners are hand sequences.
module tb_coax_transaction_ctrl;

    localparam int T = 50;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    coax_transaction_ctrl_if bus ();

    coax_transaction_ctrl #(.RESPONSE_TIMEOUT(T)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int         n_tx;
        logic [9:0] tx0;
        int         n_rx;
        logic [9:0] rx0;
        bit         drop;
        bit         stall;
        int         err_word;
        bit         exp_timeout;
        bit         exp_error;
        bit         exp_underrun;
        int         exp_loads;
        int         exp_count;
        int         exp_words;
    } vec_t;

    vec_t vecs[7];

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

    // host tx driver
    logic [9:0] tx_words[$];
    int         tx_idx;
    bit         drop_mode;
    bit         start_req;
    int         last_xfer_cyc;
    logic [9:0] tx_sb[$];
    int         loads;
    // coax_tx model
    int         tx_hold;
    bit         prev_tx_active;
    int         fall_cyc;
    // coax_rx responder
    logic [9:0] resp_words[$];
    int         resp_phase, resp_idx, resp_wait, err_word;
    bit         read_seen;
    int         pres_cyc;
    bit         pres_hv_low;
    bit         prev_read;
    int         n_reads;
    // host rx side
    logic [9:0] rx_sb[$];
    int         accepted;
    bit         stall_en, stall_done;
    int         stall_cnt;
    bit         done_seen;
    int         done_cyc;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    task automatic reset_models();
        tx_words.delete(); tx_sb.delete(); resp_words.delete(); rx_sb.delete();
        tx_idx = 0; drop_mode = 0; start_req = 0; last_xfer_cyc = -10; loads = 0;
        tx_hold = 0; prev_tx_active = 0; fall_cyc = -1;
        resp_phase = 0; resp_idx = 0; resp_wait = 0; err_word = -1; read_seen = 0;
        pres_cyc = -10; pres_hv_low = 0; prev_read = 0; n_reads = 0;
        accepted = 0; stall_en = 0; stall_done = 0; stall_cnt = 0;
        done_seen = 0; done_cyc = -1;
        bus.start = 0; bus.host_tx_data = '0; bus.host_tx_valid = 0; bus.host_tx_last = 0;
        bus.host_rx_ready = 0; bus.tx_ready = 1; bus.tx_active = 0;
        bus.rx_data = '0; bus.rx_data_available = 0; bus.rx_active = 0; bus.rx_error = 0;
    endtask

    // One clock: observe registered outputs, advance models, drive inputs.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (bus.tx_load) begin
            loads++;
            check("tx_load_latency", cyc, last_xfer_cyc + 1);
            check("tx_sb_nonempty", int'(tx_sb.size() > 0), 1);
            if (tx_sb.size() > 0) check("tx_data", bus.tx_data, tx_sb.pop_front());
        end
        if (bus.done) begin
            done_seen = 1;
            done_cyc  = cyc;
        end
        // coax_tx: frame stays active for a while after each load
        if (bus.tx_load) begin
            bus.tx_active = 1;
            tx_hold = 8;
        end else if (tx_hold > 0) begin
            tx_hold--;
            if (tx_hold == 0) bus.tx_active = 0;
        end
        if (prev_tx_active && !bus.tx_active) begin
            fall_cyc = cyc;
            if (resp_words.size() > 0) begin
                resp_phase = 1;
                resp_wait  = 4;
            end
        end
        prev_tx_active = bus.tx_active;
        // coax_rx responder
        case (resp_phase)
            1: begin
                resp_wait--;
                if (resp_wait == 0) begin
                    bus.rx_active = 1; resp_phase = 2; resp_wait = 3; resp_idx = 0;
                end
            end
            2: begin
                resp_wait--;
                if (resp_wait == 0) begin
                    if (resp_idx == err_word) begin
                        bus.rx_error = 1;
                        resp_phase = 5;
                    end else begin
                        bus.rx_data = resp_words[resp_idx];
                        bus.rx_data_available = 1;
                        rx_sb.push_back(resp_words[resp_idx]);
                        pres_cyc = cyc;
                        pres_hv_low = !bus.host_rx_valid;
                        read_seen = 0;
                        resp_phase = 3;
                    end
                end
            end
            3: begin
                if (read_seen) begin
                    bus.rx_data_available = 0;
                    resp_idx++;
                    resp_wait  = 2;
                    resp_phase = (resp_idx == resp_words.size()) ? 4 : 2;
                end
            end
            4: begin
                resp_wait--;
                if (resp_wait == 0) begin
                    bus.rx_active = 0; resp_phase = 0;
                end
            end
            5: begin
                bus.rx_error = 0; bus.rx_active = 0; resp_phase = 0;
            end
            default: ;
        endcase
        if (bus.rx_data_read) begin
            n_reads++;
            check("rx_read_single", int'(prev_read), 0);
            check("rx_read_with_valid", bus.host_rx_valid, 1);
            if (pres_hv_low) check("rx_read_latency", cyc, pres_cyc + 1);
            read_seen = 1;
        end
        prev_read = bus.rx_data_read;
        // host rx side, with one long stall on the second word
        if (stall_en && !stall_done && bus.host_rx_valid && accepted == 1) begin
            stall_cnt  = 20;
            stall_done = 1;
        end
        bus.host_rx_ready = (stall_cnt == 0);
        if (stall_cnt > 0) stall_cnt--;
        // host tx side
        bus.start = start_req;
        start_req = 0;
        bus.host_tx_valid = (tx_idx < tx_words.size()) && !(drop_mode && tx_idx >= 1);
        bus.host_tx_data  = (tx_idx < tx_words.size()) ? tx_words[tx_idx] : 10'h0;
        bus.host_tx_last  = (tx_idx == tx_words.size() - 1);
        #1;
        if (bus.host_tx_ready) begin
            check("ready_blocked_by_load", bus.tx_load, 0);
            tx_sb.push_back(bus.host_tx_data);
            last_xfer_cyc = cyc;
            tx_idx++;
        end
        if (bus.host_rx_valid && bus.host_rx_ready) begin
            accepted++;
            check("rx_sb_nonempty", int'(rx_sb.size() > 0), 1);
            if (rx_sb.size() > 0) check("host_rx_data", bus.host_rx_data, rx_sb.pop_front());
        end
    endtask

    task automatic setup_vec(input vec_t v);
        reset_models();
        tx_words.push_back(v.tx0);
        for (int i = 1; i < v.n_tx; i++) tx_words.push_back(10'($urandom_range(0, 1023)));
        if (v.n_rx > 0) resp_words.push_back(v.rx0);
        for (int i = 1; i < v.n_rx; i++) resp_words.push_back(10'($urandom_range(0, 1023)));
        drop_mode = v.drop;
        stall_en  = v.stall;
        err_word  = v.err_word;
        bus.host_rx_ready = 1;
    endtask

    task automatic run_txn(input int idx, input vec_t v);
        setup_vec(v);
        start_req = 1;
        tick();
        check("ready_outside_tx", bus.host_tx_ready, 0);
        tick();
        check("busy_after_start", bus.busy, 1);
        for (int k = 0; k < 6000 && !done_seen; k++) tick();
        check("done_seen", int'(done_seen), 1);
        if (v.exp_timeout) check("timeout_latency", done_cyc - fall_cyc, T + 2);
        check("status_timeout", bus.status_timeout, v.exp_timeout);
        check("status_error", bus.status_error, v.exp_error);
        check("status_underrun", bus.status_underrun, v.exp_underrun);
        check("rx_count", bus.rx_count, v.exp_count);
        check("busy_at_done", bus.busy, 0);
        check("tx_loads", loads, v.exp_loads);
        tick();
        check("done_one_cycle", bus.done, 0);
        for (int k = 0; k < 10; k++) tick();
        check("words_delivered", accepted, v.exp_words);
        check("rx_sb_drained", rx_sb.size(), 0);
        $display("vector %0d: tx=%0d rx=%0d loads=%0d delivered=%0d rx_count=%0d to/err/ur=%0d%0d%0d",
                 idx, v.n_tx, v.n_rx, loads, accepted, bus.rx_count,
                 bus.status_timeout, bus.status_error, bus.status_underrun);
    endtask

    initial begin
        #2_000_000;
        n_miss++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        //           ntx tx0      nrx  rx0      drp stl err  to er ur loads cnt words
        vecs[0] = '{1, 10'h005, 1,   10'h3FF, 0, 0, -1, 0, 0, 0, 1, 1,   1};
        vecs[1] = '{3, 10'h011, 4,   10'h222, 0, 1, -1, 0, 0, 0, 3, 4,   4};
        vecs[2] = '{2, 10'h0A5, 0,   10'h000, 0, 0, -1, 1, 0, 0, 2, 0,   0};
        vecs[3] = '{2, 10'h155, 0,   10'h000, 1, 0, -1, 0, 0, 1, 1, 0,   0};
        vecs[4] = '{2, 10'h2AA, 3,   10'h123, 0, 0, 1,  0, 1, 0, 2, 1,   1};
        vecs[5] = '{1, 10'h3C3, 2,   10'h000, 0, 0, -1, 0, 0, 0, 1, 2,   2};
        vecs[6] = '{1, 10'h001, 257, 10'h100, 0, 0, -1, 0, 0, 0, 1, 255, 257};

        reset = 1;
        reset_models();
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_tx_load", bus.tx_load, 0);
        check("reset_tx_data", bus.tx_data, 0);
        check("reset_host_rx_valid", bus.host_rx_valid, 0);
        check("reset_host_rx_data", bus.host_rx_data, 0);
        check("reset_rx_data_read", bus.rx_data_read, 0);
        check("reset_rx_count", bus.rx_count, 0);
        check("reset_status", {bus.status_timeout, bus.status_error, bus.status_underrun}, 0);
        reset = 0;
        tick();

        for (int i = 0; i < 7; i++) run_txn(i, vecs[i]);

        // Reset in the middle of response collection.
        setup_vec(vecs[1]);
        stall_en = 0;
        start_req = 1;
        for (int k = 0; k < 500 && !bus.host_rx_valid; k++) tick();
        check("reached_rx_collect", bus.host_rx_valid, 1);
        #2;
        reset = 1;
        #1;
        check("midreset_busy", bus.busy, 0);
        check("midreset_host_rx_valid", bus.host_rx_valid, 0);
        check("midreset_rx_data_read", bus.rx_data_read, 0);
        check("midreset_rx_count", bus.rx_count, 0);
        check("midreset_host_tx_ready", bus.host_tx_ready, 0);
        $display("mid-collect reset: busy=%0d host_rx_valid=%0d rx_count=%0d",
                 bus.busy, bus.host_rx_valid, bus.rx_count);
        reset_models();
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        bus.host_rx_ready = 1;
        for (int k = 0; k < 5; k++) tick();
        check("no_load_after_reset", loads, 0);
        check("no_read_after_reset", n_reads, 0);
        check("idle_after_reset", bus.busy, 0);
        run_txn(7, vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
